// File: rtl/avl_led_csr_pkg.sv
// avl_led_csr_pkg: register addresses, ID default and byte-lane merge helper
// shared by the LED/switch CSR agent.
package avl_led_csr_pkg;

   localparam logic [2:0] ADDR_LED_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
   localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_SW_IN        = 3'd3;
   localparam logic [2:0] ADDR_EDGE_CAP     = 3'd4;
   localparam logic [2:0] ADDR_ID           = 3'd5;
   localparam logic [2:0] ADDR_IRQ_MASK     = 3'd6;

   localparam logic [31:0] ID_VALUE_DEFAULT = 32'h1ED5_0001;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/avl_led_csr_agent_if.sv
// avl_led_csr_agent_if: Avalon-MM bus between the HPS initiator and the
// LED CSR agent; member names keep the original avs_* port names.
interface avl_led_csr_agent_if;

   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_readdata, avs_readdatavalid, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_readdata, avs_readdatavalid, avs_waitrequest
   );

endinterface

// File: rtl/avl_led_csr_agent_led_blink_timer.sv
// led_blink_timer: period counter and blink phase; a period of zero holds
// the engine idle and any period write restarts it from phase 0.
module led_blink_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] period,
   input  logic        period_wr,
   output logic        ph_next
);

   logic [31:0] cnt_q, cnt_d;
   logic        ph_q, ph_d;

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      ph_d  = ph_q;
      if (period_wr || period == '0) begin
         cnt_d = '0;
         ph_d  = 1'b0;
      end else if (cnt_q == period - 32'd1) begin
         cnt_d = '0;
         ph_d  = ~ph_q;
      end
      ph_next = ph_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ph_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ph_q  <= ph_d;
      end
   end

endmodule

// File: rtl/avl_led_csr_agent.sv
// avl_led_csr_agent: Avalon-MM CSR agent driving LEDs with per-bit blink and
// capturing switch rising edges. Define LED_CSR_IRQ_EN for IRQ_MASK and irq.
module avl_led_csr_agent
   import avl_led_csr_pkg::*;
#(
   parameter int unsigned LED_W          = 8,
   parameter int unsigned SW_W           = 4,
   parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000,
   parameter logic [31:0] ID_VALUE       = ID_VALUE_DEFAULT
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   avl_led_csr_agent_if.slave avs,
   input  logic [SW_W-1:0]    sw_in,
   output logic [LED_W-1:0]   led_out
`ifdef LED_CSR_IRQ_EN
   ,
   output logic               irq
`endif
);

   logic [LED_W-1:0] led_data_q, led_data_d;
   logic [LED_W-1:0] blink_mask_q, blink_mask_d;
   logic [31:0]      period_q, period_d;
   logic [SW_W-1:0]  edge_cap_q, edge_cap_d;
   logic [SW_W-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [LED_W-1:0] led_out_q, led_out_d;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rdata_q, rdata_d;
`ifdef LED_CSR_IRQ_EN
   logic [SW_W-1:0]  irq_mask_q, irq_mask_d;
   logic             irq_q, irq_d;
`endif

   logic [31:0]      rd_val, wr_merged, wr_clr;
   logic [SW_W-1:0]  clr_bits;
   logic             period_wr, ph_next;
   logic             unused_bits;

   led_blink_timer u_blink (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .period    (period_q),
      .period_wr (period_wr),
      .ph_next   (ph_next)
   );

   always_comb begin
      rd_val = '0;
      case (avs.avs_address)
         ADDR_LED_DATA:     rd_val = 32'(led_data_q);
         ADDR_BLINK_MASK:   rd_val = 32'(blink_mask_q);
         ADDR_BLINK_PERIOD: rd_val = period_q;
         ADDR_SW_IN:        rd_val = 32'(s2_q);
         ADDR_EDGE_CAP:     rd_val = 32'(edge_cap_q);
         ADDR_ID:           rd_val = ID_VALUE;
`ifdef LED_CSR_IRQ_EN
         ADDR_IRQ_MASK:     rd_val = 32'(irq_mask_q);
`endif
         default:           rd_val = '0;
      endcase

      // rd_val doubles as the old value for the byte-lane merge of a write
      wr_merged = be_merge(rd_val, avs.avs_writedata, avs.avs_byteenable);
      wr_clr    = be_merge('0, avs.avs_writedata, avs.avs_byteenable);

      led_data_d   = led_data_q;
      blink_mask_d = blink_mask_q;
      period_d     = period_q;
      period_wr    = 1'b0;
      clr_bits     = '0;
`ifdef LED_CSR_IRQ_EN
      irq_mask_d   = irq_mask_q;
`endif
      if (avs.avs_write) begin
         case (avs.avs_address)
            ADDR_LED_DATA:   led_data_d   = wr_merged[LED_W-1:0];
            ADDR_BLINK_MASK: blink_mask_d = wr_merged[LED_W-1:0];
            ADDR_BLINK_PERIOD: begin
               period_d  = wr_merged;
               period_wr = |avs.avs_byteenable;
            end
            ADDR_EDGE_CAP:   clr_bits     = wr_clr[SW_W-1:0];
`ifdef LED_CSR_IRQ_EN
            ADDR_IRQ_MASK:   irq_mask_d   = wr_merged[SW_W-1:0];
`endif
            default: ;
         endcase
      end

      s1_d = sw_in;
      s2_d = s1_q;
      s3_d = s2_q;
      // set after clear so a coincident rising edge wins
      edge_cap_d = (edge_cap_q & ~clr_bits) | (s2_q & ~s3_q);

      led_out_d = led_data_d ^ (blink_mask_d & {LED_W{ph_next}});

      rvalid_d = avs.avs_read & ~avs.avs_write;
      rdata_d  = rvalid_d ? rd_val : '0;
`ifdef LED_CSR_IRQ_EN
      irq_d    = |(edge_cap_q & irq_mask_q);
`endif
   end

   assign unused_bits = ^{wr_merged, wr_clr};

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         led_data_q   <= '0;
         blink_mask_q <= '0;
         period_q     <= DEFAULT_PERIOD;
         edge_cap_q   <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         s3_q         <= '0;
         led_out_q    <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
`ifdef LED_CSR_IRQ_EN
         irq_mask_q   <= '0;
         irq_q        <= 1'b0;
`endif
      end else begin
         led_data_q   <= led_data_d;
         blink_mask_q <= blink_mask_d;
         period_q     <= period_d;
         edge_cap_q   <= edge_cap_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         led_out_q    <= led_out_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
`ifdef LED_CSR_IRQ_EN
         irq_mask_q   <= irq_mask_d;
         irq_q        <= irq_d;
`endif
      end
   end

   assign led_out               = led_out_q;
   assign avs.avs_readdata      = rdata_q;
   assign avs.avs_readdatavalid = rvalid_q;
   assign avs.avs_waitrequest   = 1'b0;
`ifdef LED_CSR_IRQ_EN
   assign irq                   = irq_q;
`endif

endmodule
